// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with memory-wait timeout and sticky halt.
// Optional perf counters are built when PIPE_PERF_COUNTERS_EN is defined; otherwise they read 0.
module pipeline_stall_controller #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_hazard,
  input  logic             ctrl_hazard,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  input  logic             halt_wb,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    IMEM_WAIT = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             halted_reg, halted_next;
  logic             mem_error_reg, mem_error_next;
  logic             dmem_stall;
  logic             flush_fire;
  logic             wait_pending;

  assign dmem_stall = dmem_req & ~dmem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      halted_reg    <= 1'b0;
      mem_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      halted_reg    <= halted_next;
      mem_error_reg <= mem_error_next;
    end
  end

  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_write     = 1'b1;
    idex_flush     = 1'b0;
    exmem_write    = 1'b1;
    memwb_write    = 1'b1;
    memwb_bubble   = 1'b0;
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    halted_next    = halted_reg;
    mem_error_next = mem_error_reg;
    flush_fire     = 1'b0;
    wait_pending   = 1'b0;

    if (state_reg == HALT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else begin
      if (dmem_stall) begin
        // Whole pipe freezes; WB gets a bubble so the held instruction cannot retire twice.
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_write  = 1'b0;
        memwb_bubble = 1'b1;
        state_next   = DMEM_WAIT;
      end else begin
        state_next = RUN;
        if (ctrl_hazard) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_fire = 1'b1;
        end else if (data_hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else if (!imem_ready) begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          state_next = IMEM_WAIT;
        end
        // The ecall retires this cycle; freezing starts on the next one.
        if (halt_wb) begin
          halted_next = 1'b1;
          state_next  = HALT;
        end
      end

      // Staying in the same wait state counts up; entering or leaving one restarts at 0.
      wait_pending = (state_next == state_reg) &&
                     ((state_reg == DMEM_WAIT) || (state_reg == IMEM_WAIT));
      if (wait_pending) begin
        if (wait_cnt_reg != '1) begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
        if ((WAIT_TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(WAIT_TIMEOUT))) begin
          mem_error_next = 1'b1;
          state_next     = HALT;
        end
      end else begin
        wait_cnt_next = '0;
      end
    end

    if (!reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_write   = 1'b0;
      idex_flush   = 1'b0;
      exmem_write  = 1'b0;
      memwb_write  = 1'b0;
      memwb_bubble = 1'b0;
      flush_fire   = 1'b0;
    end
  end

  assign halted    = halted_reg;
  assign mem_error = mem_error_reg;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_cnt_reg, stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_reg <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (!halted_reg) begin
      cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      if (!pc_write) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_fire) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: expected enable vectors are queued at drive time
// and popped on the falling edge; registered outputs are checked 1 time unit after the rising edge.
module tb_pipeline_stall_controller;

  localparam int CNT_W = 32;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_write, memwb_bubble}
  localparam logic [7:0] EN_NORM   = 8'b1101_0110;
  localparam logic [7:0] EN_FROZEN = 8'b0000_0001;
  localparam logic [7:0] EN_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] EN_LU     = 8'b0001_1110;
  localparam logic [7:0] EN_IMISS  = 8'b0111_0110;
  localparam logic [7:0] EN_ZERO   = 8'b0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             data_hazard, ctrl_hazard, dmem_req, dmem_ready, imem_ready, halt_wb;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic             exmem_write, memwb_write, memwb_bubble, halted, mem_error;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [7:0]       en_obs;

  typedef struct {
    string      tag;
    logic [7:0] en;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  pipeline_stall_controller #(.WAIT_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_hazard  (data_hazard),
    .ctrl_hazard  (ctrl_hazard),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .imem_ready   (imem_ready),
    .halt_wb      (halt_wb),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_flush   (idex_flush),
    .exmem_write  (exmem_write),
    .memwb_write  (memwb_write),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .mem_error    (mem_error),
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  assign en_obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                   exmem_write, memwb_write, memwb_bubble};

  // Counters read 0 unless the perf-counter build is selected.
  function automatic logic [CNT_W-1:0] perf(input int v);
`ifdef PIPE_PERF_COUNTERS_EN
    return CNT_W'(v);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, CNT_W'(en_obs), CNT_W'(e.en));
    end
  endtask

  // One clock cycle: drive at posedge+1, compare enables at negedge, return at next posedge+1.
  task automatic step(input string tag, input logic dh, input logic ch, input logic dreq,
                      input logic drdy, input logic irdy, input logic hw, input logic [7:0] exp);
    exp_t e;
    data_hazard = dh;
    ctrl_hazard = ch;
    dmem_req    = dreq;
    dmem_ready  = drdy;
    imem_ready  = irdy;
    halt_wb     = hw;
    e.tag = tag;
    e.en  = exp;
    sb_q.push_back(e);
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_hazard = 1'b0;
    ctrl_hazard = 1'b0;
    dmem_req    = 1'b0;
    dmem_ready  = 1'b1;
    imem_ready  = 1'b1;
    halt_wb     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    // Reset state, with a dmem stall presented to show reset gating dominates.
    idle_inputs();
    dmem_req   = 1'b1;
    dmem_ready = 1'b0;
    reset      = 1'b0;
    #2;
    e.tag = "rst_enables";
    e.en  = EN_ZERO;
    sb_q.push_back(e);
    pop_cmp();
    chk("rst_halted", CNT_W'(halted), '0);
    chk("rst_memerr", CNT_W'(mem_error), '0);
    chk("rst_cycle", cycle_cnt, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    step("rst_first", 0, 0, 0, 1, 1, 0, EN_NORM);

    // Load-use bubble for one cycle.
    do_reset();
    step("lu", 1, 0, 0, 1, 1, 0, EN_LU);
    chk("lu_stall", stall_cnt, perf(1));
    step("lu_after", 0, 0, 0, 1, 1, 0, EN_NORM);
    chk("lu_cycle", cycle_cnt, perf(2));
    chk("lu_stall2", stall_cnt, perf(1));

    // Mispredict together with load-use: flush only.
    do_reset();
    step("mp_lu", 1, 1, 0, 1, 1, 0, EN_FLUSH);
    chk("mp_flushcnt", flush_cnt, perf(1));
    chk("mp_stallcnt", stall_cnt, perf(0));
    step("mp_after", 0, 0, 0, 1, 1, 0, EN_NORM);

    // Dmem miss for three cycles, then completion.
    do_reset();
    for (int i = 0; i < 3; i++) step("dmiss", 0, 0, 1, 0, 1, 0, EN_FROZEN);
    step("dmiss_done", 0, 0, 1, 1, 1, 0, EN_NORM);
    step("dmiss_run", 0, 0, 0, 1, 1, 0, EN_NORM);
    chk("dmiss_stall", stall_cnt, perf(3));

    // Imem miss, resume, and a dmem stall arriving during IMEM_WAIT.
    do_reset();
    step("imiss1", 0, 0, 0, 1, 0, 0, EN_IMISS);
    step("imiss2", 0, 0, 0, 1, 0, 0, EN_IMISS);
    step("imiss_done", 0, 0, 0, 1, 1, 0, EN_NORM);
    step("imiss3", 0, 0, 0, 1, 0, 0, EN_IMISS);
    step("imiss_dstall", 0, 0, 1, 0, 0, 0, EN_FROZEN);
    step("imiss_drel", 0, 0, 1, 1, 1, 0, EN_NORM);
    chk("imiss_halted", CNT_W'(halted), '0);

    // Halt held during a dmem stall takes effect on release.
    do_reset();
    step("hd_stall", 0, 0, 1, 0, 1, 1, EN_FROZEN);
    chk("hd_nohalt", CNT_W'(halted), '0);
    step("hd_release", 0, 0, 1, 1, 1, 1, EN_NORM);
    chk("hd_halted", CNT_W'(halted), 1);
    step("hd_frozen", 0, 0, 0, 1, 1, 0, EN_ZERO);

    // Timeout with WAIT_TIMEOUT=4: error after the 6th stalled edge.
    do_reset();
    for (int i = 0; i < 5; i++) step("to_stall", 0, 0, 1, 0, 1, 0, EN_FROZEN);
    chk("to_pre_err", CNT_W'(mem_error), '0);
    step("to_stall6", 0, 0, 1, 0, 1, 0, EN_FROZEN);
    chk("to_memerr", CNT_W'(mem_error), 1);
    chk("to_halted", CNT_W'(halted), '0);
    step("to_dead", 0, 0, 0, 1, 1, 0, EN_ZERO);
    step("to_dead2", 0, 1, 0, 1, 1, 1, EN_ZERO);

    // Halt: retiring cycle advances, then everything freezes.
    do_reset();
    step("h_run1", 0, 0, 0, 1, 1, 0, EN_NORM);
    step("h_run2", 0, 0, 0, 1, 1, 0, EN_NORM);
    step("h_ecall", 0, 0, 0, 1, 1, 1, EN_NORM);
    chk("h_halted", CNT_W'(halted), 1);
    chk("h_cycle", cycle_cnt, perf(3));
    for (int i = 0; i < 3; i++) step("h_frozen", 0, 0, 0, 1, 1, 0, EN_ZERO);
    chk("h_cycle_frz", cycle_cnt, perf(3));

    // Reset asserted in the middle of DMEM_WAIT.
    do_reset();
    step("mr_stall1", 0, 0, 1, 0, 1, 0, EN_FROZEN);
    step("mr_stall2", 0, 0, 1, 0, 1, 0, EN_FROZEN);
    dmem_req   = 1'b1;
    dmem_ready = 1'b0;
    reset      = 1'b0;
    #1;
    e.tag = "mr_enables";
    e.en  = EN_ZERO;
    sb_q.push_back(e);
    pop_cmp();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    chk("mr_cycle", cycle_cnt, '0);
    chk("mr_stallcnt", stall_cnt, '0);
    step("mr_run", 0, 0, 0, 1, 1, 0, EN_NORM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
